multicycle_control: RTL and testbench

//  Main control FSM of the multicycle CPU and the initiator of the ALU-control interface.

---
 rtl/multicycle_control.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of a multicycle CPU.
//   - Decodes the 4-bit opcode.
//   - Sequences the fetch/decode/execute/memory/writeback steps.
//   - Drives the datapath mux/enable lines and the one-hot aluop for ALU
//     control: 001 = add, 010 = sub, 100 = R-type (ALU control uses func).
//
// Memory handshake:
//   mem_read or mem_write is held high for as long as the FSM sits in
//   FETCH, MEM_RD or MEM_WR. The access completes in the cycle where
//   mem_ready is high. If the wait runs MEM_TIMEOUT consecutive cycles
//   without mem_ready, the core raises bus_err and halts. A mem_ready that
//   arrives on that final cycle still completes the access normally.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode[3:0]       IR[15:12], valid from DECODE onward
//   mem_ready         memory completes the current read/write this cycle
//   aluop[2:0]        one-hot ALU class (000 = none)
//   alu_src_a         0=PC, 1=regA
//   alu_src_b[1:0]    00=regB, 01=1, 10=sign-ext imm, 11=sign-ext offset
//   pc_write          unconditional PC load
//   pc_write_cond     PC load if ALU zero
//   pc_src[1:0]       00=ALU result, 01=ALUOut, 10=jump target
//   iord              0=PC addresses memory, 1=ALUOut
//   mem_read          memory read request
//   mem_write         memory write request
//   ir_write          IR load
//   reg_write         register file write
//   reg_dst           0=rt, 1=rd
//   mem_to_reg        0=ALUOut, 1=MDR
//   halted            core stopped (HALT or bus error)
//   illegal           sticky: undefined opcode seen
//   bus_err           sticky: memory timeout
//   retired[CNT_W-1:0] retired-instruction count, wraps
//   dbg_state[3:0]    current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             mem_ready,
    output logic [2:0]       aluop,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       dbg_state
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_retired;
    logic              r_illegal;
    logic              r_bus_err;
    logic              w_wait_state;
    logic              w_wait_lim;
    logic              w_timeout;
    logic              w_retire;
    logic              w_illegal_op;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                          (r_state == S_MEM_WR);
    // Last permitted wait cycle with no ready: this one becomes the timeout.
    assign w_wait_lim   = (r_wait == WAIT_W'(MEM_TIMEOUT - 1)) && !mem_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter, sticky flags, retirement counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait    <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            // Staying in a wait state means mem_ready was low this cycle.
            // Any state change clears the counter for the next wait.
            if (w_wait_state && (w_next == r_state)) begin
                r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_illegal_op) begin
                r_illegal <= 1'b1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next       = r_state;
        w_timeout    = 1'b0;
        w_retire     = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_wait_lim) begin
                    w_next    = S_HALT;
                    w_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    4'b0000: w_next = S_EXEC_R;
                    4'b0001: w_next = S_EXEC_I;
                    4'b0010,
                    4'b0011: w_next = S_MEM_ADDR;
                    4'b0100: w_next = S_BRANCH;
                    4'b0101: w_next = S_JUMP;
                    4'b1111: w_next = S_HALT;
                    default: begin
                        w_next       = S_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: w_next = S_WB_R;
            S_WB_R: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_EXEC_I: w_next = S_WB_I;
            S_WB_I: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            // Only 0010 (load) and 0011 (store) reach here; bit 0 selects.
            S_MEM_ADDR: w_next = opcode[0] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) begin
                    w_next = S_WB_MEM;
                end else if (w_wait_lim) begin
                    w_next    = S_HALT;
                    w_timeout = 1'b1;
                end
            end
            S_WB_MEM: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_wait_lim) begin
                    w_next    = S_HALT;
                    w_timeout = 1'b1;
                end
            end
            S_BRANCH: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode (Moore, except IR/PC write in FETCH which follow mem_ready)
    always_comb begin
        aluop         = 3'b000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        halted        = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                aluop     = 3'b001;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                aluop     = 3'b001;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                aluop     = 3'b100;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                aluop     = 3'b001;
            end
            S_WB_I: reg_write = 1'b1;
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                aluop         = 3'b010;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign illegal   = r_illegal;
    assign bus_err   = r_bus_err;
    assign retired   = r_retired;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int CNT_W = 8;   // narrow counter so wrap-around is reached quickly
    localparam int TO    = 15;  // memory timeout in cycles

    // Control word fields, MSB first:
    // aluop[3] src_a src_b[2] pc_write pc_write_cond pc_src[2] iord
    // mem_read mem_write ir_write reg_write reg_dst mem_to_reg halted
    localparam logic [17:0] C_ZERO     = 18'b000_0_00_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [17:0] C_FETCH    = 18'b001_0_01_0_0_00_0_1_0_0_0_0_0_0;
    localparam logic [17:0] C_FETCH_OK = 18'b001_0_01_1_0_00_0_1_0_1_0_0_0_0;
    localparam logic [17:0] C_DECODE   = 18'b001_0_11_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [17:0] C_EXEC_R   = 18'b100_1_00_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [17:0] C_WB_R     = 18'b000_0_00_0_0_00_0_0_0_0_1_1_0_0;
    localparam logic [17:0] C_ADDI     = 18'b001_1_10_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [17:0] C_WB_I     = 18'b000_0_00_0_0_00_0_0_0_0_1_0_0_0;
    localparam logic [17:0] C_MEM_RD   = 18'b000_0_00_0_0_00_1_1_0_0_0_0_0_0;
    localparam logic [17:0] C_WB_MEM   = 18'b000_0_00_0_0_00_0_0_0_0_1_0_1_0;
    localparam logic [17:0] C_MEM_WR   = 18'b000_0_00_0_0_00_1_0_1_0_0_0_0_0;
    localparam logic [17:0] C_BRANCH   = 18'b010_1_00_0_1_01_0_0_0_0_0_0_0_0;
    localparam logic [17:0] C_JUMP     = 18'b000_0_00_1_0_10_0_0_0_0_0_0_0_0;
    localparam logic [17:0] C_HALT     = 18'b000_0_00_0_0_00_0_0_0_0_0_0_0_1;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [3:0]       opcode = 4'b0000;
    logic             mem_ready = 1'b0;
    logic [2:0]       aluop;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_src;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             halted;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] retired;
    logic [3:0]       dbg_state;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .aluop(aluop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal),
        .bus_err(bus_err), .retired(retired), .dbg_state(dbg_state)
    );

    logic [27:0] obs;
    assign obs = {aluop, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_src,
                  iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                  mem_to_reg, halted, illegal, bus_err, retired};

    // ---------------- scoreboard / reference model ----------------
    logic [27:0]      exp_q[$];
    logic             rdy_q[$];
    string            tag_q[$];
    logic             m_illegal;
    logic             m_bus_err;
    logic [CNT_W-1:0] m_retired;
    int               n_chk = 0;
    int               n_err = 0;

    task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // One expected cycle: the mem_ready to drive, the control word the
    // specification defines for that step, and the architectural flags as
    // they stand before this cycle's events take effect.
    task automatic push(input logic rdy, input logic [17:0] c, input string tag);
        rdy_q.push_back(rdy);
        exp_q.push_back({c, m_illegal, m_bus_err, m_retired});
        tag_q.push_back(tag);
    endtask

    task automatic push_any(input logic [17:0] c, input string tag);
        push(1'($urandom_range(0, 1)), c, tag);
    endtask

    task automatic halt_tail();
        repeat (4) push_any(C_HALT, "halt");
    endtask

    // A memory wait of n cycles; n >= TO means memory never answers in time.
    task automatic mem_phase(input logic [17:0] c_wait, input logic [17:0] c_ok,
                             input string tag, input int n, output bit timed_out);
        timed_out = 1'b0;
        if (n >= TO) begin
            repeat (TO) push(1'b0, c_wait, tag);
            m_bus_err = 1'b1;
            timed_out = 1'b1;
        end else begin
            repeat (n) push(1'b0, c_wait, tag);
            push(1'b1, c_ok, tag);
        end
    endtask

    // Expected cycle sequence for one instruction starting in FETCH.
    task automatic build(input logic [3:0] op, input int wf, input int wm, output bit stopped);
        bit to;
        stopped = 1'b0;
        mem_phase(C_FETCH, C_FETCH_OK, "fetch", wf, to);
        if (to) begin
            halt_tail();
            stopped = 1'b1;
            return;
        end
        push_any(C_DECODE, "decode");
        case (op)
            4'b0000: begin
                push_any(C_EXEC_R, "exec_r");
                push_any(C_WB_R, "wb_r");
                m_retired++;
            end
            4'b0001: begin
                push_any(C_ADDI, "exec_i");
                push_any(C_WB_I, "wb_i");
                m_retired++;
            end
            4'b0010: begin
                push_any(C_ADDI, "mem_addr");
                mem_phase(C_MEM_RD, C_MEM_RD, "mem_rd", wm, to);
                if (to) begin
                    halt_tail();
                    stopped = 1'b1;
                end else begin
                    push_any(C_WB_MEM, "wb_mem");
                    m_retired++;
                end
            end
            4'b0011: begin
                push_any(C_ADDI, "mem_addr");
                mem_phase(C_MEM_WR, C_MEM_WR, "mem_wr", wm, to);
                if (to) begin
                    halt_tail();
                    stopped = 1'b1;
                end else begin
                    m_retired++;
                end
            end
            4'b0100: begin
                push_any(C_BRANCH, "branch");
                m_retired++;
            end
            4'b0101: begin
                push_any(C_JUMP, "jump");
                m_retired++;
            end
            4'b1111: begin
                halt_tail();
                stopped = 1'b1;
            end
            default: m_illegal = 1'b1;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // Entered at posedge+1; drives one cycle and checks at the falling edge.
    task automatic step();
        string tag;
        mem_ready = rdy_q.pop_front();
        tag = tag_q.pop_front();
        @(negedge clk);
        chk(tag, obs, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n && exp_q.size() > 0; i++) step();
    endtask

    task automatic run_all();
        while (exp_q.size() > 0) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #2;
        chk("reset_async", obs, 28'd0);
        exp_q.delete();
        rdy_q.delete();
        tag_q.delete();
        m_illegal = 1'b0;
        m_bus_err = 1'b0;
        m_retired = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle", obs, 28'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [3:0] op, input int wf, input int wm);
        bit stopped;
        opcode = op;
        build(op, wf, wm, stopped);
        run_all();
        if (stopped) do_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit s;
        int wf;
        int wm;
        logic [3:0] op;

        #1;
        do_reset();

        // Directed scenarios
        do_instr(4'b0000, 0, 0);    // R-type
        do_instr(4'b0010, 0, 3);    // load with 3 wait cycles
        do_instr(4'b0100, 1, 0);    // branch
        do_instr(4'b0011, 0, 2);    // store
        do_instr(4'b0001, 2, 0);    // immediate
        do_instr(4'b0101, 0, 0);    // jump
        do_instr(4'b1010, 0, 0);    // illegal, sticky
        do_instr(4'b0000, 0, 0);
        do_instr(4'b1111, 0, 0);    // halt, then reset
        do_instr(4'b0000, 14, 0);   // ready arrives on the last allowed cycle
        do_instr(4'b0000, 15, 0);   // fetch timeout -> bus_err, halt
        do_instr(4'b0010, 0, 14);
        do_instr(4'b0010, 0, 15);   // load timeout
        do_instr(4'b0011, 0, 15);   // store timeout

        // Reset in the middle of a store wait
        opcode = 4'b0011;
        build(4'b0011, 0, 10, s);
        run_n(6);
        do_reset();

        // Long run without halts: counter wraps past 2^CNT_W-1
        for (int i = 0; i < 320; i++) begin
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(6, 14));
            else op = 4'($urandom_range(0, 5));
            do_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Mixed run including halts and timeouts
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            wf = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 2);
            wm = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 2);
            do_instr(op, wf, wm);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
